// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads,
// and buffers {inst, addr} pairs in a small in-order FIFO toward decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_addr;
  logic          r_drop;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0]   r_mem_d [FIFO_DEPTH];
  logic [31:0]   r_mem_a [FIFO_DEPTH];

  logic w_valid;
  logic w_gnt;
  logic w_rsp;
  logic w_push;
  logic w_pop;

  assign w_valid = (r_count != '0);
  assign w_gnt   = (r_state == S_REQ) && imem_gnt_i;
  assign w_rsp   = (r_state == S_WAIT) && imem_rvalid_i;
  assign w_push  = w_rsp && !r_drop && !jump_en_i;
  assign w_pop   = w_valid && inst_ready_i && !jump_en_i;

  // Redirect flushes the buffer, so occupancy restarts at zero.
  always_comb begin
    w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
    if (jump_en_i)
      w_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (jump_en_i)
          w_state_nxt = hold_i ? S_IDLE : S_REQ;
        else if (!hold_i && (r_count < DEPTH_C))
          w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt_i)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i)
          w_state_nxt = (!hold_i && (w_cnt_nxt < DEPTH_C)) ? S_REQ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o   = (r_state == S_REQ);
    imem_addr_o  = r_pc;
    inst_valid_o = w_valid;
    inst_o       = w_valid ? r_mem_d[r_rptr] : NOP_INST;
    inst_addr_o  = w_valid ? r_mem_a[r_rptr] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_fetch_addr <= '0;
      r_drop       <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (jump_en_i) begin
        r_pc   <= {jump_addr_i[31:2], 2'b00};
        // Anything granted or still in flight belongs to the old path.
        r_drop <= w_gnt || ((r_state == S_WAIT) && !imem_rvalid_i);
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_gnt) begin
          r_pc         <= r_pc + 32'd4;
          r_fetch_addr <= r_pc;
        end
        if (w_rsp)
          r_drop <= 1'b0;
        if (w_push)
          r_wptr <= r_wptr + PW'(1);
        if (w_pop)
          r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wptr] <= imem_rdata_i;
      r_mem_a[r_wptr] <= r_fetch_addr;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: fetch flow, back-pressure, redirects,
// grant stalls, mid-operation reset and PC wrap.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic req,
                      input logic [31:0] addr, input logic vld,
                      input logic [31:0] ins, input logic [31:0] iaddr);
    chk({tag, ".req"}, 32'(imem_req_o), 32'(req));
    chk({tag, ".addr"}, imem_addr_o, addr);
    chk({tag, ".vld"}, 32'(inst_valid_o), 32'(vld));
    chk({tag, ".inst"}, inst_o, ins);
    chk({tag, ".iaddr"}, inst_addr_o, iaddr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    jump_en_i     = 1'b0;
    jump_addr_i   = '0;
    hold_i        = 1'b0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    inst_ready_i  = 1'b1;

    // Reset state
    do_reset();
    outs("rst", 1'b0, 32'h0, 1'b0, NOP, 32'h0);

    // 1: streaming fetch with immediate grant
    tick();
    outs("t1.req0", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    tick();
    chk("t1.wait0.req", 32'(imem_req_o), 32'h0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0050_0093;
    tick();
    outs("t1.d0", 1'b1, 32'h4, 1'b1, 32'h0050_0093, 32'h0);
    imem_rvalid_i = 1'b0;
    tick();
    chk("t1.pop0.vld", 32'(inst_valid_o), 32'h0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0010_0113;
    tick();
    outs("t1.d1", 1'b1, 32'h8, 1'b1, 32'h0010_0113, 32'h4);
    imem_rvalid_i = 1'b0;

    // 2: back-pressure fills the buffer, then drains in order
    do_reset();
    inst_ready_i = 1'b0;
    tick();
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0050_0093;
    tick();
    imem_rvalid_i = 1'b0;
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0010_0113;
    tick();
    imem_rvalid_i = 1'b0;
    outs("t2.full", 1'b0, 32'h8, 1'b1, 32'h0050_0093, 32'h0);
    tick();
    tick();
    outs("t2.stall", 1'b0, 32'h8, 1'b1, 32'h0050_0093, 32'h0);
    inst_ready_i = 1'b1;
    tick();
    outs("t2.pop0", 1'b0, 32'h8, 1'b1, 32'h0010_0113, 32'h4);
    tick();
    outs("t2.pop1", 1'b1, 32'h8, 1'b0, NOP, 32'h0);

    // 3: redirect while waiting drops the in-flight response
    do_reset();
    tick();
    tick();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0103;
    tick();
    jump_en_i = 1'b0;
    outs("t3.jmp", 1'b0, 32'h100, 1'b0, NOP, 32'h0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    outs("t3.drop", 1'b1, 32'h100, 1'b0, NOP, 32'h0);
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0030_0193;
    tick();
    imem_rvalid_i = 1'b0;
    outs("t3.new", 1'b1, 32'h104, 1'b1, 32'h0030_0193, 32'h100);

    // 4: redirect coincident with rvalid and pop flushes everything
    inst_ready_i = 1'b0;
    tick();
    inst_ready_i  = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0040_0213;
    jump_en_i     = 1'b1;
    jump_addr_i   = 32'h0000_0200;
    tick();
    jump_en_i     = 1'b0;
    imem_rvalid_i = 1'b0;
    outs("t4.flush", 1'b1, 32'h200, 1'b0, NOP, 32'h0);
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0050_0293;
    tick();
    imem_rvalid_i = 1'b0;
    outs("t4.new", 1'b1, 32'h204, 1'b1, 32'h0050_0293, 32'h200);

    // 5: grant withheld with hold pulsing; request stays stable
    imem_gnt_i = 1'b0;
    hold_i     = 1'b1;
    tick();
    outs("t5.s0", 1'b1, 32'h204, 1'b0, NOP, 32'h0);
    hold_i = 1'b0;
    tick();
    outs("t5.s1", 1'b1, 32'h204, 1'b0, NOP, 32'h0);
    hold_i = 1'b1;
    tick();
    outs("t5.s2", 1'b1, 32'h204, 1'b0, NOP, 32'h0);
    imem_gnt_i = 1'b1;
    tick();
    chk("t5.gnt.req", 32'(imem_req_o), 32'h0);
    chk("t5.gnt.pc", imem_addr_o, 32'h208);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0060_0313;
    tick();
    imem_rvalid_i = 1'b0;
    outs("t5.rsp", 1'b0, 32'h208, 1'b1, 32'h0060_0313, 32'h204);
    tick();
    outs("t5.held", 1'b0, 32'h208, 1'b0, NOP, 32'h0);

    // 6: reset during WAIT, stray rvalid afterwards ignored
    hold_i = 1'b0;
    tick();
    chk("t6.req", imem_addr_o, 32'h208);
    tick();
    rst_n = 1'b0;
    tick();
    outs("t6.rst", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    rst_n         = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid_i = 1'b0;
    outs("t6.stray", 1'b1, 32'h0, 1'b0, NOP, 32'h0);

    // PC wrap at top of address space
    imem_gnt_i  = 1'b0;
    jump_en_i   = 1'b1;
    jump_addr_i = 32'hFFFF_FFFF;
    tick();
    jump_en_i = 1'b0;
    chk("wrap.tgt", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap.req", 32'(imem_req_o), 32'h1);
    imem_gnt_i = 1'b1;
    tick();
    chk("wrap.pc", imem_addr_o, 32'h0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0070_0393;
    tick();
    imem_rvalid_i = 1'b0;
    outs("wrap.d", 1'b1, 32'h0, 1'b1, 32'h0070_0393, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
